// File: rtl/icon_anim_ctrl_pkg.sv
// rtl/icon_anim_ctrl_pkg.sv - heading codes, FSM states and heading helpers for icon_anim_ctrl
package icon_pkg;

  localparam logic [2:0] HDG_N  = 3'd0;
  localparam logic [2:0] HDG_NE = 3'd1;
  localparam logic [2:0] HDG_E  = 3'd2;
  localparam logic [2:0] HDG_SE = 3'd3;
  localparam logic [2:0] HDG_S  = 3'd4;
  localparam logic [2:0] HDG_SW = 3'd5;
  localparam logic [2:0] HDG_W  = 3'd6;
  localparam logic [2:0] HDG_NW = 3'd7;

  typedef enum logic [1:0] {IDLE, WALK, TURN} state_t;

  // Sprite sheet rows are not stored in compass order.
  function automatic logic [2:0] hdg_to_row(input logic [2:0] hdg);
    case (hdg)
      HDG_N:   return 3'd1;
      HDG_NE:  return 3'd7;
      HDG_E:   return 3'd3;
      HDG_SE:  return 3'd5;
      HDG_S:   return 3'd0;
      HDG_SW:  return 3'd4;
      HDG_W:   return 3'd2;
      default: return 3'd6;
    endcase
  endfunction

  // Returns +1 or -1 as a 3-bit addend; a half-turn (d == 4) goes clockwise.
  function automatic logic [2:0] turn_step(input logic [2:0] cur, input logic [2:0] target);
    logic [2:0] d;
    d = target - cur;
    return (d >= 3'd1 && d <= 3'd4) ? 3'd1 : 3'd7;
  endfunction

endpackage

// File: rtl/icon_anim_ctrl_if.sv
// rtl/icon_anim_ctrl_if.sv - BotInfo in, shadowed sprite coordinates out
interface icon_anim_ctrl_if;
  logic [7:0] botinfo;
  logic       frame_start;
  logic [2:0] frame_row;
  logic [1:0] frame_col;
  logic       turning;

  modport master (output botinfo, frame_start, input frame_row, frame_col, turning);
  modport slave  (input botinfo, frame_start, output frame_row, frame_col, turning);
endinterface

// File: rtl/icon_anim_ctrl_tick_timer.sv
// rtl/icon_anim_ctrl_tick_timer.sv - reloadable down-counter with a one-cycle expire pulse
module anim_tick_timer #(
  parameter int CNT_W = 32,
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_reload,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  // An explicit reload suppresses the expire pulse in the same cycle.
  assign o_expire = i_run && !i_reload && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || i_reload || o_expire) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/icon_anim_ctrl.sv
// rtl/icon_anim_ctrl.sv - walk-cycle, idle pose and stepped turning for the Rojobot sprite icon
module icon_anim_ctrl
  import icon_pkg::*;
#(
  parameter int ANIM_TICKS = 8_000_000,
  parameter int TURN_TICKS = 2_000_000,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  icon_anim_ctrl_if.slave   bus
);

  state_t     r_state, w_state_next;
  logic [2:0] r_cur_hdg, w_hdg_next;
  logic [1:0] r_live_col, w_col_next;
  logic       r_dir_up, w_dir_next;
  logic [2:0] r_row;
  logic [1:0] r_col;
  logic       r_turning;

  logic       w_moving, w_match;
  logic [2:0] w_target;
  logic       w_anim_reload, w_turn_reload, w_anim_expire, w_turn_expire;
  logic       w_unused_bit;

  assign w_moving     = |bus.botinfo[7:4];
  assign w_target     = bus.botinfo[2:0];
  assign w_match      = (w_target == r_cur_hdg);
  assign w_unused_bit = bus.botinfo[3];

  // Counters only run while their state is actively stepping; any exit reloads them.
  assign w_anim_reload = !(r_state == WALK && w_match && w_moving);
  assign w_turn_reload = !(r_state == TURN && !w_match);

  anim_tick_timer #(.CNT_W(CNT_W), .TICKS(ANIM_TICKS)) u_anim_timer (
    .clk      (clk),
    .reset    (reset),
    .i_run    (r_state == WALK),
    .i_reload (w_anim_reload),
    .o_expire (w_anim_expire)
  );

  anim_tick_timer #(.CNT_W(CNT_W), .TICKS(TURN_TICKS)) u_turn_timer (
    .clk      (clk),
    .reset    (reset),
    .i_run    (r_state == TURN),
    .i_reload (w_turn_reload),
    .o_expire (w_turn_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_hdg_next   = r_cur_hdg;
    w_col_next   = r_live_col;
    w_dir_next   = r_dir_up;
    case (r_state)
      IDLE: begin
        w_col_next = 2'd1;
        if (!w_match) begin
          w_state_next = TURN;
        end else if (w_moving) begin
          w_state_next = WALK;
        end
      end
      WALK: begin
        if (!w_match) begin
          w_state_next = TURN;
          w_col_next   = 2'd1;
        end else if (!w_moving) begin
          w_state_next = IDLE;
          w_col_next   = 2'd1;
          w_dir_next   = 1'b1;
        end else if (w_anim_expire) begin
          w_col_next = r_dir_up ? (r_live_col + 2'd1) : (r_live_col - 2'd1);
          // Ping-pong: reverse at either end of the 0..2 column range.
          if (w_col_next == 2'd2) begin
            w_dir_next = 1'b0;
          end else if (w_col_next == 2'd0) begin
            w_dir_next = 1'b1;
          end
        end
      end
      TURN: begin
        w_col_next = 2'd1;
        if (w_match) begin
          w_state_next = w_moving ? WALK : IDLE;
        end else if (w_turn_expire) begin
          w_hdg_next = r_cur_hdg + turn_step(r_cur_hdg, w_target);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cur_hdg  <= HDG_N;
      r_live_col <= 2'd1;
      r_dir_up   <= 1'b1;
      r_row      <= hdg_to_row(HDG_N);
      r_col      <= 2'd1;
      r_turning  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_hdg  <= w_hdg_next;
      r_live_col <= w_col_next;
      r_dir_up   <= w_dir_next;
      r_turning  <= (w_state_next == TURN);
      // Shadow copy uses pre-update values so the renderer never sees a mid-frame change.
      if (bus.frame_start) begin
        r_row <= hdg_to_row(r_cur_hdg);
        r_col <= r_live_col;
      end
    end
  end

  assign bus.frame_row = r_row;
  assign bus.frame_col = r_col;
  assign bus.turning   = r_turning;

endmodule

// File: tb/tb_icon_anim_ctrl.sv
// tb/tb_icon_anim_ctrl.sv - self-checking bench for icon_anim_ctrl
module tb_icon_anim_ctrl;

  localparam int AT = 4;
  localparam int TT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icon_anim_ctrl_if bus();

  icon_anim_ctrl #(.ANIM_TICKS(AT), .TURN_TICKS(TT), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int row_map[8] = '{1, 7, 3, 5, 0, 4, 2, 6};
  int col_seq[4] = '{1, 2, 1, 0};

  // Reference: mode 0 idle, 1 walk, 2 turn; walk-cycle position as a phase index into col_seq.
  int m_mode, m_hdg, m_phase, m_wel, m_tel, m_row, m_col, m_turn;

  typedef struct {
    bit         rst;
    logic [7:0] bi;
    bit         fs;
    int         row;
    int         col;
    int         turn;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input logic [7:0] bi, input bit fs);
    int tgt, d;
    bit mv;
    if (rst) begin
      m_mode = 0; m_hdg = 0; m_phase = 0; m_wel = 0; m_tel = 0;
      m_row = 1; m_col = 1; m_turn = 0;
      return;
    end
    mv  = (bi[7:4] != 4'd0);
    tgt = int'(bi[2:0]);
    if (fs) begin
      m_row = row_map[m_hdg];
      m_col = col_seq[m_phase];
    end
    case (m_mode)
      0: begin
        m_wel = 0; m_tel = 0;
        if (tgt != m_hdg) m_mode = 2;
        else if (mv) m_mode = 1;
      end
      1: begin
        m_tel = 0;
        if (tgt != m_hdg) begin
          m_mode = 2; m_wel = 0;
          if (m_phase == 1) m_phase = 2;
          else if (m_phase == 3) m_phase = 0;
        end else if (!mv) begin
          m_mode = 0; m_wel = 0; m_phase = 0;
        end else begin
          m_wel++;
          if (m_wel == AT) begin
            m_wel = 0;
            m_phase = (m_phase + 1) % 4;
          end
        end
      end
      default: begin
        m_wel = 0;
        if (tgt == m_hdg) begin
          m_mode = mv ? 1 : 0; m_tel = 0;
        end else begin
          m_tel++;
          if (m_tel == TT) begin
            m_tel = 0;
            d = (tgt - m_hdg + 8) % 8;
            m_hdg = (d >= 1 && d <= 4) ? (m_hdg + 1) % 8 : (m_hdg + 7) % 8;
          end
        end
      end
    endcase
    m_turn = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic tick(input bit rst, input logic [7:0] bi, input bit fs);
    reset = rst;
    bus.botinfo = bi;
    bus.frame_start = fs;
    @(posedge clk);
    model_step(rst, bi, fs);
    #1;
    check("model_row", int'(bus.frame_row), m_row);
    check("model_col", int'(bus.frame_col), m_col);
    check("model_turning", int'(bus.turning), m_turn);
  endtask

  task automatic run_turn(input logic [7:0] bi, input int n, input int exp_rows[5]);
    int got[$];
    bit seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, bi, 1);
      if (got.size() == 0 || got[$] != int'(bus.frame_row)) got.push_back(int'(bus.frame_row));
      if (bus.turning) seen = 1;
      else if (seen) break;
    end
    check("turn_done", int'(seen && !bus.turning), 1);
    check("turn_len", got.size(), n);
    for (int i = 0; i < n; i++) begin
      check("turn_row", (i < got.size()) ? got[i] : -1, exp_rows[i]);
    end
  endtask

  logic [7:0] rbi;

  initial begin
    reset = 1'b1;
    bus.botinfo = 8'h00;
    bus.frame_start = 1'b0;

    // Reset, then a turn from heading 0 to 3 with frame_start every cycle.
    vecs[0] = '{1'b1, 8'h00, 1'b0, 1, 1, 0};
    vecs[1] = '{1'b0, 8'h03, 1'b1, 1, 1, 1};
    vecs[2] = '{1'b0, 8'h03, 1'b1, 1, 1, 1};
    vecs[3] = '{1'b0, 8'h03, 1'b1, 1, 1, 1};
    vecs[4] = '{1'b0, 8'h03, 1'b1, 7, 1, 1};
    vecs[5] = '{1'b0, 8'h03, 1'b1, 7, 1, 1};
    vecs[6] = '{1'b0, 8'h03, 1'b1, 3, 1, 1};
    vecs[7] = '{1'b0, 8'h03, 1'b1, 3, 1, 1};
    vecs[8] = '{1'b0, 8'h03, 1'b1, 5, 1, 0};
    vecs[9] = '{1'b0, 8'h03, 1'b1, 5, 1, 0};
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].rst, vecs[i].bi, vecs[i].fs);
      check("vec_row", int'(bus.frame_row), vecs[i].row);
      check("vec_col", int'(bus.frame_col), vecs[i].col);
      check("vec_turning", int'(bus.turning), vecs[i].turn);
    end

    // Idle pose holds regardless of frame pulses.
    tick(1, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 8'h00, 1'($urandom_range(0, 1)));
      check("idle_row", int'(bus.frame_row), 1);
      check("idle_col", int'(bus.frame_col), 1);
      check("idle_turning", int'(bus.turning), 0);
    end

    // Walk cycle ping-pong, one column step per AT clocks.
    tick(1, 8'h00, 0);
    for (int n = 1; n <= 21; n++) begin
      tick(0, 8'h10, 1);
      if (n >= 2) check("walk_col", int'(bus.frame_col), col_seq[((n - 2) / AT) % 4]);
      check("walk_row", int'(bus.frame_row), 1);
    end

    // Half-turn tie goes clockwise; 0 -> 7 is a single counter-clockwise step.
    tick(1, 8'h00, 0);
    run_turn(8'h04, 5, '{1, 7, 3, 5, 0});
    tick(1, 8'h00, 0);
    run_turn(8'h07, 2, '{1, 6, 0, 0, 0});

    // Long gap without frame_start, then a single pulse.
    tick(1, 8'h00, 0);
    tick(0, 8'h10, 1);
    for (int i = 0; i < 10; i++) tick(0, 8'h10, 0);
    tick(0, 8'h10, 1);

    // Column step coincident with frame_start shows the pre-step column.
    tick(1, 8'h00, 0);
    tick(0, 8'h10, 0);
    for (int i = 0; i < AT - 1; i++) tick(0, 8'h10, 0);
    tick(0, 8'h10, 1);
    check("pre_step_col", int'(bus.frame_col), 1);
    tick(0, 8'h10, 1);
    check("post_step_col", int'(bus.frame_col), 2);

    // Reset in the middle of a turn, then the turn restarts from heading 0.
    tick(1, 8'h00, 0);
    for (int i = 0; i < 3; i++) tick(0, 8'h15, 1);
    tick(1, 8'h15, 1);
    check("rst_row", int'(bus.frame_row), 1);
    check("rst_col", int'(bus.frame_col), 1);
    check("rst_turning", int'(bus.turning), 0);
    run_turn(8'h15, 4, '{1, 6, 2, 4, 0});

    // Randomized traffic against the reference model.
    rbi = 8'h00;
    tick(1, rbi, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rbi[7:4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        rbi[3:0] = 4'($urandom_range(0, 15));
      end
      tick(($urandom_range(0, 199) == 0), rbi, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
